oled_spi_receiver: RTL
======================

# oled_spi_receiver

Passive SPI receiver for the pmod OLED link driven by `Oled_Display`. It samples `cs`/`sdin`/`sclk`/`d_cn` on `basys_clk` and rebuilds the controller's view of the stream: command bytes, and RGB565 pixels tagged with their 96x64 raster index. Uses:
- mirror the right-hand OLED frame into game logic;
- capture frames for on-board self-check;
- act as the bench-side checker for any OLED driver in the design.

## Interface
Parameters:
- `PIXELS`, 6144: pixels per frame (96x64); pixel index wraps at `PIXELS-1`.
- `IDX_W`, 13: pixel index width.

Ports:
- `basys_clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  chip select, active-low, asynchronous to `basys_clk`.
- `sclk`  in  1  SPI clock; data sampled on rising edge; MSB first.
- `sdin`  in  1  serial data.
- `d_cn`  in  1  data/command select: 1 = data, 0 = command. Sampled with bit 0 of each byte.
- `cmd_valid`  out  1  one-cycle strobe: `cmd_byte` holds a new command byte.
- `cmd_byte`  out  8  last command byte received.
- `pixel_valid`  out  1  one-cycle strobe: `pixel_data`/`pixel_index` hold a new pixel.
- `pixel_data`  out  16  RGB565 value, first data byte in [15:8].
- `pixel_index`  out  `IDX_W`  raster index of `pixel_data` (0..`PIXELS-1`).
- `frame_done`  out  1  one-cycle strobe, coincident with `pixel_valid` for index `PIXELS-1`.
- `sync_err`  out  1  sticky; set on partial byte at `cs` deassertion. Cleared only by reset.

## Operation
- Input conditioning:
  - `cs`, `sclk`, `sdin`, `d_cn` each pass through a 2-flop synchroniser.
  - A third `sclk` flop provides rising-edge detect: `rise = s2 & ~s3`.
- Bit capture: on `rise` while synchronised `cs` = 0:
  - `shift <= {shift[6:0], sdin_s}`;
  - `bitcnt` (3 bits) increments.
- Byte complete: on a `rise` with `bitcnt`=7, the byte `{shift[6:0], sdin_s}` and `d_cn_s` are latched and `bitcnt` wraps to 0.
- Command byte (`d_cn_s`=0):
  - `cmd_byte` <= byte; `cmd_valid` pulses.
  - If byte is 0x15 (set column) or 0x75 (set row): pixel counter <= 0 and byte phase <= HI.
- Data byte (`d_cn_s`=1), byte phase alternates HI/LO:
  - HI: store byte in `hi_reg`; phase <= LO; no strobe.
  - LO: `pixel_data <= {hi_reg, byte}`, `pixel_index <= counter`, `pixel_valid` pulses.
    - counter <= (counter = `PIXELS-1`) ? 0 : counter+1.
    - `frame_done` pulses when counter was `PIXELS-1`.
    - phase <= HI.
- `cs_s` rising (deselect):
  - If `bitcnt` != 0: `sync_err` <= 1.
  - `bitcnt` <= 0 and shift register cleared.
  - Byte phase and pixel counter are kept; the driver may toggle `cs` between bytes.
- While `cs_s`=1, `sclk` edges are ignored.
- Reset values: `cmd_valid`, `pixel_valid`, `frame_done`, `sync_err` = 0; `cmd_byte`, `pixel_data`, `pixel_index` = 0. Internals: counter 0, phase HI, `bitcnt` 0.
- `reset_n` asserted mid-byte or mid-pixel: the partial byte or half-pixel is discarded. No strobe is generated for it.

## Timing
- Input constraints: `sclk` high and low phases each ≥ 3 `basys_clk` periods. `sdin` and `d_cn` stable from 2 periods before until 2 periods after each `sclk` rise.
- Latency: strobes assert for exactly 1 cycle, registered, on the 3rd `basys_clk` rising edge after the raw `sclk` rise that carries bit 0.
- Between strobes, `cmd_byte`, `pixel_data` and `pixel_index` hold their values.
- At most one of `cmd_valid`/`pixel_valid` per byte. `frame_done` only ever accompanies `pixel_valid`.
- A `cs` rise and the final `sclk` rise in the same synchronised cycle: the byte completes first, then deselect is processed. No `sync_err`.
- Throughput: sustains a 6.25 MHz `sclk` at 100 MHz `basys_clk` (16 samples per bit).

## Test plan
- Reset, then send command bytes 0x15, 0x00, 0x5F at 6.25 MHz → three `cmd_valid` pulses with `cmd_byte` = 0x15, 0x00, 0x5F. No `pixel_valid`. Each strobe lands 3 cycles after the bit-0 `sclk` rise.
- After 0x75, send data bytes 0xF8, 0x00, 0x07, 0xE0 → `pixel_valid` twice: (index 0, 0xF800), then (index 1, 0x07E0).
- Send 6144 pixels of 0x001F → last `pixel_valid` has index 6143 together with `frame_done`=1. The next pixel gets index 0.
- Send 5 bits, then raise `cs` → `sync_err`=1 and no strobe. The next full byte 0xA5 as a command gives `cmd_byte`=0xA5.
- Send data byte 0x12, then command 0x15, then data 0x34, 0x56 → one pixel only, index 0, 0x3456. The stale 0x12 is discarded.
- Drop `reset_n` after 4 bits of the HI byte, release, then send 0xAB, 0xCD as data → all outputs 0 during reset. Afterwards exactly one pixel: index 0, 0xABCD.

Source files
------------

// File: rtl/oled_spi_receiver.sv
// Passive receiver for the pmod OLED SPI link. Samples the bus on basys_clk and
// rebuilds command bytes and RGB565 pixels tagged with their raster index.
module oled_spi_receiver #(
    parameter int unsigned PIXELS = 6144,
    parameter int unsigned IDX_W  = 13
) (
    input  logic             basys_clk,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             sclk,
    input  logic             sdin,
    input  logic             d_cn,
    output logic             cmd_valid,
    output logic [7:0]       cmd_byte,
    output logic             pixel_valid,
    output logic [15:0]      pixel_data,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic             sync_err
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PIXELS - 1);

    // Synchroniser stages; cs and sclk get a third flop for edge detection.
    logic [2:0] cs_sync_q;
    logic [2:0] sclk_sync_q;
    logic [1:0] sdin_sync_q;
    logic [1:0] dcn_sync_q;

    logic             cs_s2, cs_s3, sclk_s2, sclk_s3, sdin_s, dcn_s;
    logic             sclk_rise, cs_rise, capture;
    logic [7:0]       rx_byte;

    logic [6:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             phase_lo_q, phase_lo_d;
    logic [7:0]       hi_q, hi_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             cmd_valid_d, pixel_valid_d, frame_done_d, sync_err_d;
    logic [7:0]       cmd_byte_d;
    logic [15:0]      pixel_data_d;
    logic [IDX_W-1:0] pixel_index_d;

    // Bring the asynchronous SPI pins into the basys_clk domain.
    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b000;
            sdin_sync_q <= 2'b00;
            dcn_sync_q  <= 2'b00;
        end else begin
            cs_sync_q   <= {cs_sync_q[1:0], cs};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            sdin_sync_q <= {sdin_sync_q[0], sdin};
            dcn_sync_q  <= {dcn_sync_q[0], d_cn};
        end
    end

    assign cs_s2     = cs_sync_q[1];
    assign cs_s3     = cs_sync_q[2];
    assign sclk_s2   = sclk_sync_q[1];
    assign sclk_s3   = sclk_sync_q[2];
    assign sdin_s    = sdin_sync_q[1];
    assign dcn_s     = dcn_sync_q[1];
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;
    // A final edge coinciding with deselect still counts, so the byte completes first.
    assign capture   = sclk_rise & (~cs_s2 | cs_rise);
    assign rx_byte   = {shift_q, sdin_s};

    // Next-state: bit capture, byte decode, pixel assembly and deselect handling.
    always_comb begin
        shift_d       = shift_q;
        bitcnt_d      = bitcnt_q;
        phase_lo_d    = phase_lo_q;
        hi_d          = hi_q;
        cnt_d         = cnt_q;
        cmd_byte_d    = cmd_byte;
        pixel_data_d  = pixel_data;
        pixel_index_d = pixel_index;
        sync_err_d    = sync_err;
        cmd_valid_d   = 1'b0;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;

        if (capture) begin
            shift_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                if (!dcn_s) begin
                    cmd_byte_d  = rx_byte;
                    cmd_valid_d = 1'b1;
                    // Column/row address commands restart the raster walk.
                    if (rx_byte == 8'h15 || rx_byte == 8'h75) begin
                        cnt_d      = '0;
                        phase_lo_d = 1'b0;
                    end
                end else if (!phase_lo_q) begin
                    hi_d       = rx_byte;
                    phase_lo_d = 1'b1;
                end else begin
                    pixel_data_d  = {hi_q, rx_byte};
                    pixel_index_d = cnt_q;
                    pixel_valid_d = 1'b1;
                    phase_lo_d    = 1'b0;
                    if (cnt_q == LastIdx) begin
                        cnt_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
        end

        if (cs_rise) begin
            if (bitcnt_d != 3'd0) begin
                sync_err_d = 1'b1;
            end
            bitcnt_d = 3'd0;
            shift_d  = 7'd0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q     <= 7'd0;
            bitcnt_q    <= 3'd0;
            phase_lo_q  <= 1'b0;
            hi_q        <= 8'd0;
            cnt_q       <= '0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'd0;
            pixel_valid <= 1'b0;
            pixel_data  <= 16'd0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            phase_lo_q  <= phase_lo_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            cmd_valid   <= cmd_valid_d;
            cmd_byte    <= cmd_byte_d;
            pixel_valid <= pixel_valid_d;
            pixel_data  <= pixel_data_d;
            pixel_index <= pixel_index_d;
            frame_done  <= frame_done_d;
            sync_err    <= sync_err_d;
        end
    end

endmodule
